pts_sr_rx_frame: RTL and testbench

- Receive-side counterpart of the byte transmit shift register: serial-to-parallel receiver for the same serial link.
- Samples `serial_in` on rising-edge strobes from the shared edge detector, assembles NUM_BITS-bit words in the configured bit order and counts bits.
- Presents each completed word on a holding register with a valid/ack handshake and a sticky overrun flag.
- Sits between the link's edge-detect logic and the controller FSM / register interface.

---
 rtl/pts_sr_rx_frame_pkg.sv | 15 +
 rtl/pts_sr_rx_frame_if.sv | 22 ++
 rtl/flex_stp_sr.sv | 40 ++++
 rtl/pts_sr_rx_frame.sv | 113 +++++++++++
 tb/tb_pts_sr_rx_frame.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pts_sr_rx_frame_pkg.sv
// Shared serial-link definitions: receiver state encoding, bit-order constants, default width.
package pts_sr_rx_frame_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rx_state_e;

  // Bit-order selectors, shared with the transmit path's SHIFT_MSB.
  localparam bit MSB_FIRST = 1'b1;
  localparam bit LSB_FIRST = 1'b0;

  localparam int unsigned DEFAULT_NUM_BITS = 8;

endpackage

// File: rtl/pts_sr_rx_frame_if.sv
// Word-side handshake between the receiver (master) and its consumer (slave).
interface pts_sr_rx_frame_if #(
  parameter int unsigned NUM_BITS = pts_sr_rx_frame_pkg::DEFAULT_NUM_BITS
);
  logic [NUM_BITS-1:0]              rx_data;
  logic                             rx_valid;
  logic                             rx_ack;
  logic                             overrun;
  logic                             clear_overrun;
  logic                             busy;
  logic [$clog2(NUM_BITS+1)-1:0]    bit_count;

  modport master (
    output rx_data, rx_valid, overrun, busy, bit_count,
    input  rx_ack, clear_overrun
  );

  modport slave (
    input  rx_data, rx_valid, overrun, busy, bit_count,
    output rx_ack, clear_overrun
  );
endinterface

// File: rtl/flex_stp_sr.sv
// Generic serial-to-parallel shift register with selectable bit order.
module flex_stp_sr
  import pts_sr_rx_frame_pkg::*;
#(
  parameter int unsigned NUM_BITS  = DEFAULT_NUM_BITS,
  parameter bit          SHIFT_MSB = MSB_FIRST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                shift_enable_i,
  input  logic                clear_i,
  input  logic                serial_in_i,
  // Includes the bit being shifted in this cycle, so a completed word is visible immediately.
  output logic [NUM_BITS-1:0] parallel_out_o
);

  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] shifted;

  if (SHIFT_MSB) begin : g_msb
    assign shifted = {sr_q[NUM_BITS-2:0], serial_in_i};
  end else begin : g_lsb
    assign shifted = {serial_in_i, sr_q[NUM_BITS-1:1]};
  end

  // Post-shift view of the register.
  always_comb begin
    parallel_out_o = shift_enable_i ? shifted : sr_q;
  end

  // Shift register state; clear beats shift.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sr_q <= '0;
    end else if (shift_enable_i) begin
      sr_q <= shifted;
    end
  end

endmodule

// File: rtl/pts_sr_rx_frame.sv
// Serial receiver: assembles words on serial-clock rising edges, hands them off with valid/ack.
module pts_sr_rx_frame
  import pts_sr_rx_frame_pkg::*;
#(
  parameter int unsigned NUM_BITS  = DEFAULT_NUM_BITS,
  parameter bit          SHIFT_MSB = MSB_FIRST
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rising_edge_i,
  input  logic               rx_enable_i,
  input  logic               abort_i,
  input  logic               serial_in_i,
  pts_sr_rx_frame_if.master  rx_if
);

  localparam int unsigned    CntW    = $clog2(NUM_BITS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_BITS - 1);

  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                sample, discard, complete;
  logic [NUM_BITS-1:0] word;

  // Abort wins over a coincident serial edge.
  assign sample  = rx_enable_i & rising_edge_i & ~abort_i;
  assign discard = abort_i | ~rx_enable_i;

  flex_stp_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .shift_enable_i (sample),
    .clear_i        (discard),
    .serial_in_i    (serial_in_i),
    .parallel_out_o (word)
  );

  // Bit-count FSM: explicit last-bit compare, no reliance on counter wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (discard) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (sample) begin
      unique case (state_q)
        StIdle: begin
          state_d = StShift;
          cnt_d   = CntW'(1);
        end
        StShift: begin
          if (cnt_q == LastIdx) begin
            complete = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Holding register, valid/ack handshake and sticky overrun (set beats clear).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~rx_if.rx_ack;
    ovr_d   = ovr_q & ~rx_if.clear_overrun;
    if (complete) begin
      if (!valid_q || rx_if.rx_ack) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.overrun   = ovr_q;
  assign rx_if.bit_count = cnt_q;
  assign rx_if.busy      = (state_q == StShift);

endmodule

// File: tb/tb_pts_sr_rx_frame.sv
// Bench for pts_sr_rx_frame: MSB-first and LSB-first instances share one stimulus stream.
module tb_pts_sr_rx_frame;
  import pts_sr_rx_frame_pkg::*;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0, re = 1'b0, en = 1'b0, ab = 1'b0, sin = 1'b0, ack = 1'b0, clr = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  pts_sr_rx_frame_if #(.NUM_BITS(N)) if_m ();
  pts_sr_rx_frame_if #(.NUM_BITS(N)) if_l ();

  assign if_m.rx_ack        = ack;
  assign if_m.clear_overrun = clr;
  assign if_l.rx_ack        = ack;
  assign if_l.clear_overrun = clr;

  pts_sr_rx_frame #(.NUM_BITS(N), .SHIFT_MSB(MSB_FIRST)) u_dut_m (
    .clk_i(clk), .rst_i(rst), .rising_edge_i(re), .rx_enable_i(en),
    .abort_i(ab), .serial_in_i(sin), .rx_if(if_m)
  );

  pts_sr_rx_frame #(.NUM_BITS(N), .SHIFT_MSB(LSB_FIRST)) u_dut_l (
    .clk_i(clk), .rst_i(rst), .rising_edge_i(re), .rx_enable_i(en),
    .abort_i(ab), .serial_in_i(sin), .rx_if(if_l)
  );

  // Reference model: received bits kept as a list, words built by arithmetic on bit positions.
  bit       mb[$];
  logic [7:0] m_msb = '0, m_lsb = '0;
  logic     m_valid = 1'b0, m_ovr = 1'b0;

  always @(posedge clk) begin : model
    logic       done, drop;
    logic [7:0] wm, wl;
    done = 1'b0; drop = 1'b0; wm = '0; wl = '0;
    if (rst) begin
      mb.delete();
      m_msb = '0; m_lsb = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (ab || !en) begin
        mb.delete();
      end else if (re) begin
        mb.push_back(sin);
        if (mb.size() == N) begin
          for (int i = 0; i < N; i++) begin
            wm = wm | (8'(mb[i]) << (N - 1 - i));
            wl = wl | (8'(mb[i]) << i);
          end
          done = 1'b1;
          mb.delete();
        end
      end
      if (done && (!m_valid || ack)) begin
        m_msb = wm; m_lsb = wl; m_valid = 1'b1;
      end else if (done) begin
        drop = 1'b1;
      end else if (ack) begin
        m_valid = 1'b0;
      end
      if (drop)     m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data",  16'(if_m.rx_data),   16'(m_msb));
      chk("l_data",  16'(if_l.rx_data),   16'(m_lsb));
      chk("m_valid", 16'(if_m.rx_valid),  16'(m_valid));
      chk("l_valid", 16'(if_l.rx_valid),  16'(m_valid));
      chk("m_ovr",   16'(if_m.overrun),   16'(m_ovr));
      chk("l_ovr",   16'(if_l.overrun),   16'(m_ovr));
      chk("m_cnt",   16'(if_m.bit_count), 16'(mb.size()));
      chk("l_cnt",   16'(if_l.bit_count), 16'(mb.size()));
      chk("m_busy",  16'(if_m.busy),      16'(mb.size() != 0));
      chk("l_busy",  16'(if_l.busy),      16'(mb.size() != 0));
    end
  end

  // One serial rising edge every 4 clocks; optional ack in the sample cycle.
  task automatic send_bit(input logic b, input logic ack_now);
    re = 1'b1; sin = b; ack = ack_now;
    @(negedge clk);
    re = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int i = 7; i >= 0; i--) send_bit(w[i], ack_last && (i == 0));
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1; chk_en = 1'b1;
    chk("rst_cnt",   16'(if_m.bit_count), 16'd0);
    chk("rst_valid", 16'(if_m.rx_valid),  16'd0);
    chk("rst_busy",  16'(if_l.busy),      16'd0);

    // 0xA5 MSB-first; its bit reversal is also 0xA5
    send_word(8'hA5, 1'b0);
    chk("a5_m", 16'(if_m.rx_data), 16'h00A5);
    chk("a5_l", 16'(if_l.rx_data), 16'h00A5);
    chk("a5_model", 16'(m_msb), 16'h00A5);
    pulse_ack();

    // Bit sequence 1,0,0,0,0,0,0,0
    send_word(8'h80, 1'b0);
    chk("one_m", 16'(if_m.rx_data), 16'h0080);
    chk("one_l", 16'(if_l.rx_data), 16'h0001);
    chk("one_model", 16'(m_lsb), 16'h0001);
    pulse_ack();

    // Abort coincident with a serial edge after 5 bits
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    re = 1'b1; ab = 1'b1; sin = 1'b1;
    @(negedge clk);
    re = 1'b0; ab = 1'b0;
    chk("abort_cnt",   16'(if_m.bit_count), 16'd0);
    chk("abort_busy",  16'(if_m.busy),      16'd0);
    chk("abort_valid", 16'(if_m.rx_valid),  16'd0);
    repeat (3) @(negedge clk);
    send_word(8'h3C, 1'b0);
    chk("3c_m", 16'(if_m.rx_data), 16'h003C);
    chk("3c_l", 16'(if_l.rx_data), 16'h003C);
    pulse_ack();

    // Overrun, clear, then completion with coincident ack
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("ovr_m_data", 16'(if_m.rx_data), 16'h0011);
    chk("ovr_l_data", 16'(if_l.rx_data), 16'h0088);
    chk("ovr_flag",   16'(if_m.overrun), 16'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", 16'(if_m.overrun), 16'd0);
    send_word(8'h33, 1'b1);
    chk("33_m",     16'(if_m.rx_data),  16'h0033);
    chk("33_l",     16'(if_l.rx_data),  16'h00CC);
    chk("33_valid", 16'(if_m.rx_valid), 16'd1);
    chk("33_ovr",   16'(if_m.overrun),  16'd0);
    pulse_ack();

    // Enable drop after 3 bits
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("en_cnt", 16'(if_m.bit_count), 16'd0);
    send_word(8'h5A, 1'b0);
    chk("5a_m", 16'(if_m.rx_data), 16'h005A);
    chk("5a_l", 16'(if_l.rx_data), 16'h005A);

    // Reset mid-word with valid and overrun set
    send_word(8'h00, 1'b0);
    chk("pre_ovr", 16'(if_m.overrun), 16'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("pre_cnt", 16'(if_m.bit_count), 16'd4);
    rst = 1'b1;
    #2;
    chk("sync_cnt",   16'(if_m.bit_count), 16'd4);
    chk("sync_valid", 16'(if_m.rx_valid),  16'd1);
    chk("sync_ovr",   16'(if_m.overrun),   16'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_cnt",   16'(if_m.bit_count), 16'd0);
    chk("rst2_valid", 16'(if_m.rx_valid),  16'd0);
    chk("rst2_ovr",   16'(if_m.overrun),   16'd0);
    chk("rst2_data",  16'(if_m.rx_data),   16'd0);
    chk("rst2_busy",  16'(if_m.busy),      16'd0);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
